// File: rtl/adpll_gain_sequencer.sv
// Gain-scheduling / programming sequencer for the ADPLL core: clear, acquisition gains, lock watch,
// tracking gains, loss-of-lock fallback. Optional acquisition timeout via ADPLL_SEQ_TIMEOUT_EN.
module adpll_gain_sequencer #(
    parameter int         W      = 5,
    parameter int         LCW    = 8,
    parameter int         TOW    = 12,
    parameter logic [2:0] SEL_KP = 3'd0,
    parameter logic [2:0] SEL_KI = 3'd1,
    parameter int         LOSS_N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           stop,
    input  logic [W-1:0]   err_mag,
    input  logic [W-1:0]   acq_kp,
    input  logic [W-1:0]   acq_ki,
    input  logic [W-1:0]   trk_kp,
    input  logic [W-1:0]   trk_ki,
    input  logic [W-1:0]   lock_thresh,
    input  logic [LCW-1:0] lock_cycles,
    output logic           clr,
    output logic           pgm,
    output logic [2:0]     param_sel,
    output logic [W-1:0]   pgm_value,
    output logic           locked,
    output logic           busy,
    output logic [2:0]     state,
    output logic           timeout
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        LOAD_ACQ = 3'd2,
        ACQUIRE  = 3'd3,
        LOAD_TRK = 3'd4,
        TRACK    = 3'd5
    } state_e;

    localparam int LSW = $clog2(LOSS_N + 1);

    state_e         state_q, state_d;
    logic [2:0]     step_q, step_d;
    logic [LCW-1:0] lock_q, lock_d;
    logic [LSW-1:0] loss_q, loss_d;
    logic           clr_q, clr_d, pgm_q, pgm_d, locked_q, locked_d, busy_q, busy_d;
    logic [2:0]     sel_q, sel_d;
    logic [W-1:0]   val_q, val_d;
    logic [LCW-1:0] lock_tgt;
    logic           in_win, wr_d;

    assign in_win   = (err_mag <= lock_thresh);
    assign lock_tgt = (lock_cycles == '0) ? LCW'(1) : lock_cycles;

`ifdef ADPLL_SEQ_TIMEOUT_EN
    localparam logic [TOW-1:0] TO_LAST = {{(TOW-1){1'b1}}, 1'b0};
    logic [TOW-1:0] to_q, to_d;
    logic           tmo_q, tmo_d;
    assign timeout = tmo_q;
`else
    logic [TOW-1:0] unused_tow;
    assign unused_tow = '0;
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        lock_d  = '0;
        loss_d  = '0;
`ifdef ADPLL_SEQ_TIMEOUT_EN
        to_d    = '0;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = CLEAR;
                    step_d  = '0;
`ifdef ADPLL_SEQ_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                end
            end
            CLEAR: begin
                if (step_q == 3'd1) begin
                    state_d = LOAD_ACQ;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            LOAD_ACQ, LOAD_TRK: begin
                // Two back-to-back 3-cycle writes: steps 0-2 Kp, steps 3-5 Ki
                if (step_q == 3'd5) begin
                    if (state_q == LOAD_ACQ) state_d = ACQUIRE;
                    else                     state_d = TRACK;
                    step_d = '0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ACQUIRE: begin
`ifdef ADPLL_SEQ_TIMEOUT_EN
                to_d = to_q + TOW'(1);
`endif
                if (in_win && (lock_q >= lock_tgt - LCW'(1))) begin
                    state_d = LOAD_TRK;
                    step_d  = '0;
                end else if (in_win) begin
                    lock_d = (lock_q == '1) ? lock_q : lock_q + LCW'(1);
`ifdef ADPLL_SEQ_TIMEOUT_EN
                end else if (to_q == TO_LAST) begin
                    state_d = CLEAR;
                    step_d  = '0;
                    tmo_d   = 1'b1;
`endif
                end
`ifdef ADPLL_SEQ_TIMEOUT_EN
                if (in_win && (lock_q < lock_tgt - LCW'(1)) && (to_q == TO_LAST)) begin
                    state_d = CLEAR;
                    step_d  = '0;
                    tmo_d   = 1'b1;
                end
`endif
            end
            TRACK: begin
                if (!in_win) begin
                    if (loss_q == LSW'(LOSS_N - 1)) begin
                        state_d = LOAD_ACQ;
                        step_d  = '0;
                    end else begin
                        loss_d = loss_q + LSW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
        if (stop) begin
            state_d = IDLE;
            step_d  = '0;
        end

        // Outputs are decoded from the next state so they appear registered with it
        wr_d     = (state_d == LOAD_ACQ) || (state_d == LOAD_TRK);
        clr_d    = (state_d == CLEAR);
        pgm_d    = wr_d && ((step_d == 3'd1) || (step_d == 3'd4));
        locked_d = (state_d == TRACK);
        busy_d   = (state_d != IDLE);
        sel_d    = sel_q;
        val_d    = val_q;
        if (wr_d && (step_d == 3'd0)) begin
            sel_d = SEL_KP;
            val_d = (state_d == LOAD_ACQ) ? acq_kp : trk_kp;
        end else if (wr_d && (step_d == 3'd3)) begin
            sel_d = SEL_KI;
            val_d = (state_d == LOAD_ACQ) ? acq_ki : trk_ki;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            step_q   <= '0;
            lock_q   <= '0;
            loss_q   <= '0;
            clr_q    <= 1'b0;
            pgm_q    <= 1'b0;
            locked_q <= 1'b0;
            busy_q   <= 1'b0;
            sel_q    <= '0;
            val_q    <= '0;
`ifdef ADPLL_SEQ_TIMEOUT_EN
            to_q     <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            lock_q   <= lock_d;
            loss_q   <= loss_d;
            clr_q    <= clr_d;
            pgm_q    <= pgm_d;
            locked_q <= locked_d;
            busy_q   <= busy_d;
            sel_q    <= sel_d;
            val_q    <= val_d;
`ifdef ADPLL_SEQ_TIMEOUT_EN
            to_q     <= to_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign clr       = clr_q;
    assign pgm       = pgm_q;
    assign param_sel = sel_q;
    assign pgm_value = val_q;
    assign locked    = locked_q;
    assign busy      = busy_q;
    assign state     = state_q;
endmodule
